// File: rtl/jacobian_sequencer.sv
// Schedules one Jacobian evaluation: walks count 0..MAX-1 while RUN, pulses done,
// and derives the datapath, mat_mult reset and mat_mult mode controls from the schedule.
module jacobian_sequencer #(
    parameter int MAX     = 113,
    parameter int MM_RST0 = 28,
    parameter int MM_RST1 = 98,
    parameter int MODE_LO = 90,
    parameter int MODE_HI = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       en,
    output logic       busy,
    output logic       done,
    output logic [7:0] count,
    output logic       dp_rst,
    output logic       dp_en,
    output logic       mm_rst,
    output logic       mm_mode
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] LAST    = 8'(MAX - 1);
    localparam logic [8:0] MODE_LO9 = 9'(MODE_LO);
    localparam logic [8:0] MODE_HI9 = 9'(MODE_HI);
    localparam logic [7:0] MM_TRIG [2] = '{8'(MM_RST0), 8'(MM_RST1)};

    state_t     state_reg, state_next;
    logic [7:0] count_reg, count_next;
    logic       mm_rst_reg, mm_rst_next;
    logic [1:0] trig_hit;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_trig
            assign trig_hit[gi] = (count_reg == MM_TRIG[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            count_reg  <= 8'd0;
            mm_rst_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            mm_rst_reg <= mm_rst_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        mm_rst_next = mm_rst_reg;
        if (en) begin
            mm_rst_next = (state_reg == RUN) && (|trig_hit);
        end
        case (state_reg)
            IDLE: begin
                if (start && en) begin
                    state_next = RUN;
                    count_next = 8'd0;
                end
            end
            RUN: begin
                // abort beats both the stall and the final-count completion
                if (abort) begin
                    state_next  = IDLE;
                    count_next  = 8'd0;
                    mm_rst_next = 1'b0;
                end else if (en) begin
                    if (count_reg == LAST) begin
                        state_next = DONE;
                        count_next = 8'd0;
                    end else begin
                        count_next = count_reg + 8'd1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
                count_next = 8'd0;
            end
            default: begin
                state_next = IDLE;
                count_next = 8'd0;
            end
        endcase
    end

    always_comb begin
        busy    = (state_reg == RUN);
        done    = (state_reg == DONE);
        dp_rst  = (state_reg != RUN);
        dp_en   = en && (state_reg == RUN);
        mm_mode = !((state_reg == RUN) &&
                    ({1'b0, count_reg} >= MODE_LO9) &&
                    ({1'b0, count_reg} <  MODE_HI9));
    end

    assign count  = count_reg;
    assign mm_rst = mm_rst_reg;

endmodule
